// File: rtl/div_ratio_checker.sv
// rtl/div_ratio_checker.sv - checks that a divided strobe keeps the expected clk-cycle period
module div_ratio_checker #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_ratio,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

    state_t          r_state;
    logic            r_div_d;
    logic            r_have_edge;
    logic [CNT_W-1:0] r_cnt;
    logic [MW-1:0]   r_match_cnt;

    logic            w_rise;
    logic            w_force_idle;
    logic            w_measure;
    logic            w_match;
    logic            w_cnt_sat;
    logic [MW-1:0]   w_match_inc;

    assign w_rise       = div_in & ~r_div_d & en;
    assign w_force_idle = ~en | (exp_ratio < CNT_W'(2));
    assign w_measure    = w_rise & r_have_edge & (r_state != S_IDLE);
    assign w_match      = (r_cnt == exp_ratio);
    assign w_cnt_sat    = (r_cnt == CNT_MAX);
    assign w_match_inc  = r_match_cnt + MW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div_d      <= 1'b0;
            r_have_edge  <= 1'b0;
            r_cnt        <= '0;
            r_match_cnt  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_cnt      <= '0;
        end else begin
            r_div_d      <= div_in;
            period_valid <= 1'b0;
            err          <= 1'b0;
            if (w_force_idle) begin
                // Disabling wins over a coincident rise: nothing is measured.
                r_state     <= S_IDLE;
                locked      <= 1'b0;
                r_have_edge <= 1'b0;
                r_cnt       <= '0;
                r_match_cnt <= '0;
            end else begin
                if (r_state != S_IDLE) begin
                    if (w_rise) begin
                        r_cnt       <= CNT_W'(1);
                        r_have_edge <= 1'b1;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                if (w_measure) begin
                    period       <= r_cnt;
                    period_valid <= 1'b1;
                end
                case (r_state)
                    S_IDLE: r_state <= S_ACQUIRE;
                    S_ACQUIRE: begin
                        if (w_measure) begin
                            if (w_match) begin
                                r_match_cnt <= w_match_inc;
                                if (w_match_inc == MW'(LOCK_N)) begin
                                    r_state <= S_LOCKED;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                r_match_cnt <= '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        // A saturated counter means the strobe has stopped arriving.
                        if ((w_measure && !w_match) || (!w_rise && w_cnt_sat)) begin
                            r_state <= S_FAULT;
                            locked  <= 1'b0;
                            err     <= 1'b1;
                            if (err_cnt != CNT_MAX)
                                err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end
                    S_FAULT: begin
                        if (w_measure) begin
                            r_state     <= S_ACQUIRE;
                            r_match_cnt <= w_match ? MW'(1) : MW'(0);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_ratio_checker.sv
// tb/tb_div_ratio_checker.sv - scoreboard bench for div_ratio_checker against a cycle-index reference model
module tb_div_ratio_checker;
    localparam int LOCK_N = 4;

    logic       clk = 1'b0;
    logic       rst, en, div_in;
    logic [7:0] exp_ratio;
    logic [7:0] period, err_cnt;
    logic       period_valid, locked, err;

    div_ratio_checker #(.CNT_W(8), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .exp_ratio(exp_ratio),
        .period(period), .period_valid(period_valid), .locked(locked),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       pv;
        logic [7:0] per;
        logic       er;
        logic [7:0] ec;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: time measured as cycle indices, not as a counter.
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;
    int m_st = M_IDLE, m_cyc = 0, m_last = 0, m_matches = 0, m_period = 0, m_ec = 0;
    bit m_armed = 0, m_prev = 0;

    task automatic model(input bit r, input bit e, input bit d, input int ratio);
        exp_t x;
        bit rise, meas, hit, pv, er;
        int st0, measured;
        pv = 0; er = 0;
        if (r) begin
            m_st = M_IDLE; m_armed = 0; m_matches = 0; m_period = 0; m_ec = 0; m_prev = 0;
        end else begin
            rise = d && !m_prev && e;
            m_prev = d;
            if (!e || ratio < 2) begin
                m_st = M_IDLE; m_armed = 0; m_matches = 0;
            end else begin
                st0 = m_st;
                measured = (m_cyc - m_last > 255) ? 255 : m_cyc - m_last;
                meas = rise && m_armed && st0 != M_IDLE;
                hit = meas && (measured == ratio);
                if (meas) begin m_period = measured; pv = 1; end
                case (st0)
                    M_IDLE: m_st = M_ACQ;
                    M_ACQ: if (meas) begin
                        if (hit) begin
                            m_matches++;
                            if (m_matches == LOCK_N) m_st = M_LOCK;
                        end else m_matches = 0;
                    end
                    M_LOCK: if ((meas && !hit) || (!rise && m_cyc - m_last >= 255)) begin
                        m_st = M_FAULT; er = 1;
                        if (m_ec < 255) m_ec++;
                    end
                    default: if (meas) begin m_st = M_ACQ; m_matches = hit ? 1 : 0; end
                endcase
                if (st0 != M_IDLE && rise) begin m_armed = 1; m_last = m_cyc; end
            end
        end
        m_cyc++;
        x.lk = (m_st == M_LOCK); x.pv = pv; x.per = 8'(m_period); x.er = er; x.ec = 8'(m_ec);
        q_exp.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input bit d, input int ratio);
        rst = r; en = e; div_in = d; exp_ratio = 8'(ratio);
        model(r, e, d, ratio);
        @(posedge clk);
        #1;
    endtask

    task automatic periods(input int n, input int p, input int ratio);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < p; j++) cyc(0, 1, j == 0, ratio);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every sampled cycle consumes one expected response.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                x = q_exp.pop_front();
                chk("period_valid", period_valid, x.pv);
                chk("err", err, x.er);
                chk("locked", locked, x.lk);
                chk("err_cnt", err_cnt, x.ec);
                if (x.pv || period_valid) chk("period", period, x.per);
                else if (x.per == 0) chk("period_level", period, 0);
            end
        end
    end

    initial begin
        int ratio_v, p, sel;
        // Reset overrides an enabled, rising strobe.
        cyc(1, 1, 1, 3);
        cyc(1, 1, 0, 3);
        // Acquire and lock at divide-by-3.
        periods(8, 3, 3);
        // One long period: lock loss, then reacquire.
        periods(1, 4, 3);
        periods(6, 3, 3);
        // Missing edges: counter saturation while locked.
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 3);
        periods(7, 3, 3);
        // en drops on a rise cycle, then re-enable.
        cyc(0, 1, 0, 3);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 0, 3);
        periods(7, 3, 3);
        // Invalid ratio with a toggling strobe.
        for (int i = 0; i < 20; i++) cyc(0, 1, i[0], 1);
        periods(6, 5, 5);
        // Ratio change while locked is judged at the next rise.
        periods(2, 5, 6);
        periods(6, 6, 6);
        // Randomised periods, ratio changes and enable drops.
        ratio_v = 3;
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) ratio_v = $urandom_range(2, 7);
            p = (sel < 3) ? ratio_v + 1 : (sel == 3 ? ratio_v - 1 : ratio_v);
            if (p < 2) p = 2;
            if (sel == 19) cyc(0, 0, 1, ratio_v);
            for (int j = 0; j < p; j++) cyc(0, 1, j == 0, ratio_v);
        end
        // Reset while locked: no err pulse, everything cleared.
        periods(8, 4, 4);
        cyc(1, 1, 1, 4);
        periods(3, 4, 4);
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_ratio_checker.md
DIV_RATIO_CHECKER -- requirements
Module: div_ratio_checker

Interface
REQ-001 Parameters SHALL be:
- CNT_W, default 8, width of the period counter and all period fields.
- LOCK_N, default 4, number of consecutive matching periods needed to declare lock.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  checker enable; 0 forces IDLE.
- div_in  in  1  divided clock/strobe under test, synchronous to clk.
- exp_ratio  in  CNT_W  expected divide ratio, in clk cycles per div_in period.
- period  out  CNT_W  last measured rise-to-rise period.
- period_valid  out  1  one-cycle pulse when period updates.
- locked  out  1  high while state==LOCKED.
- err  out  1  one-cycle pulse on a lock loss.
- err_cnt  out  CNT_W  saturating count of lock losses.
REQ-003 The block SHALL have no asynchronous logic and no clocks derived from div_in.

Function
REQ-004 The block SHALL register div_in into div_d each cycle.
- rise = div_in & ~div_d & en.
REQ-005 Counter cnt SHALL update as follows:
- On rise: load 1.
- Otherwise, when en=1: increment, saturating at 2^CNT_W-1.
REQ-006 The measured value at a rise SHALL be the cnt value before the load.
- Example: with a divide-by-3 input, rises 3 cycles apart measure 3.
REQ-007 The first rise after reset, after en rising, or after leaving IDLE SHALL only arm the measurement (have_edge<=1).
- It SHALL NOT produce period_valid.
REQ-008 On each later rise, period<=measured and period_valid<=1 SHALL be registered at that same clock edge.
- period_valid SHALL be 0 on all other cycles.
REQ-009 match SHALL be defined as measured==exp_ratio.
REQ-010 State machine: states IDLE, ACQUIRE, LOCKED, FAULT.
REQ-011 IDLE:
- Go to ACQUIRE when en=1 and exp_ratio>=2.
- Otherwise stay in IDLE.
REQ-012 ACQUIRE, on each measured rise:
- match: match_cnt++.
- mismatch: match_cnt<=0.
- When match_cnt reaches LOCK_N, go to LOCKED.
REQ-013 LOCKED, go to FAULT on either of:
- A measured rise with mismatch.
- cnt reaching saturation (missing edges).
REQ-014 On entry to FAULT:
- err<=1 for exactly one cycle.
- err_cnt increments, saturating at 2^CNT_W-1.
REQ-015 FAULT, on the next measured rise:
- Go to ACQUIRE.
- match_cnt<=1 if match, else 0.
- No further err pulses while in FAULT.
REQ-016 From any state, en=0 or exp_ratio<2 SHALL force IDLE on the next edge.
- Clears have_edge, cnt, and match_cnt.
- Leaves err_cnt and period unchanged.
REQ-017 When en falls on the same cycle as a rise, en SHALL win: no measurement and no err.
REQ-018 A change of exp_ratio while LOCKED SHALL be evaluated on the next measured rise.
- A mismatch then is a lock loss per REQ-013.
REQ-019 locked SHALL be registered and equal to (state==LOCKED).

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE.
- div_d=0, cnt=0, have_edge=0, match_cnt=0.
- period=0, period_valid=0, locked=0, err=0, err_cnt=0.
REQ-021 rst SHALL override en and div_in on the same cycle.
REQ-022 Reset mid-lock SHALL drop locked on the next cycle without an err pulse.

Verification
REQ-023 Lock: exp_ratio=3, en=1, div_in = divide-by-3 pattern (one cycle high, two low).
- First rise: no valid.
- Next 4 rises: period=3 with period_valid pulses.
- locked=1 after the 4th measured period; err_cnt=0.
REQ-024 Lock loss: while locked at ratio 3, insert one period of 4.
- That rise: period=4.
- err pulses once; err_cnt=1; locked=0.
- 4 more good periods: locked=1 again.
REQ-025 Missing edge: while locked, hold div_in low.
- After cnt saturates at 255: err=1, err_cnt increments, locked=0.
REQ-026 Enable/collision:
- Deassert en on a rise cycle: no period_valid, no err, state IDLE next cycle.
- Re-enable: first rise is arm-only.
REQ-027 Invalid ratio: exp_ratio=1 with toggling div_in.
- Stays in IDLE; period_valid never asserts.
REQ-028 Reset: assert rst mid-LOCKED with err_cnt=2.
- Next cycle: all outputs 0, including err_cnt; no err pulse.
